// File: rtl/shift_reg_r.sv
// shift_reg_r: WIDTH-bit universal shift register with asynchronous active-low reset.
//
// Purpose: a general-purpose register that can also serialise (load, then shift out)
// or deserialise (shift in, then read q). It also counts shifts since the last
// load/clear and flags when that count reaches WIDTH.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset (clears q and shift_cnt)
//   en         clock enable; 0 holds all state (clr is ignored too)
//   clr        synchronous clear; overrides mode when en=1
//   mode       2'b00 hold, 2'b01 shift right, 2'b10 shift left, 2'b11 parallel load
//   d          parallel load data
//   si_r       serial input for a right shift (enters q[WIDTH-1])
//   si_l       serial input for a left shift (enters q[0])
//   rot        (SHIFT_REG_ROTATE_EN only) rotate instead of taking si_r/si_l
//   q          register contents
//   so_r       q[0], the bit that leaves on the next right shift
//   so_l       q[WIDTH-1], the bit that leaves on the next left shift
//   shift_cnt  shifts since last load/clear, saturating at WIDTH
//   done       high while shift_cnt == WIDTH
//
// Optional feature: define SHIFT_REG_ROTATE_EN to add the rot input.

module shift_reg_r #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             si_r,
  input  logic             si_l,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic             so_r,
  output logic             so_l,
  output logic [CW-1:0]    shift_cnt,
  output logic             done
);

  localparam logic [CW-1:0] CntMax = CW'(WIDTH);

  localparam logic [1:0] ModeHold  = 2'b00;
  localparam logic [1:0] ModeRight = 2'b01;
  localparam logic [1:0] ModeLeft  = 2'b10;
  localparam logic [1:0] ModeLoad  = 2'b11;

  logic [WIDTH-1:0] q_d, q_q;
  logic [CW-1:0]    cnt_d, cnt_q;
  logic             in_r, in_l;
  logic [CW-1:0]    cnt_inc;

  // Bits entering on a shift; rotation feeds back the bit that leaves.
`ifdef SHIFT_REG_ROTATE_EN
  assign in_r = rot ? q_q[0]       : si_r;
  assign in_l = rot ? q_q[WIDTH-1] : si_l;
`else
  assign in_r = si_r;
  assign in_l = si_l;
`endif

  // Saturating increment: the count sticks at WIDTH while data keeps shifting.
  assign cnt_inc = (cnt_q < CntMax) ? cnt_q + CW'(1) : cnt_q;

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    if (en) begin
      if (clr) begin
        q_d   = '0;
        cnt_d = '0;
      end else begin
        case (mode)
          ModeHold: begin
            q_d   = q_q;
            cnt_d = cnt_q;
          end
          ModeRight: begin
            q_d   = {in_r, q_q[WIDTH-1:1]};
            cnt_d = cnt_inc;
          end
          ModeLeft: begin
            q_d   = {q_q[WIDTH-2:0], in_l};
            cnt_d = cnt_inc;
          end
          ModeLoad: begin
            q_d   = d;
            cnt_d = '0;
          end
          default: begin
            q_d   = q_q;
            cnt_d = cnt_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  // Pure decodes of registered state.
  assign q         = q_q;
  assign so_r      = q_q[0];
  assign so_l      = q_q[WIDTH-1];
  assign shift_cnt = cnt_q;
  assign done      = (cnt_q == CntMax);

endmodule
